// File: rtl/clock_divider_multi.sv
// Multi-channel clock-enable generator: per-channel tick strobes and
// 50% square enables with shadowed, boundary-applied divide ratios.
module clock_divider_multi #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 16,
  parameter int RESET_DIV = 2,
  parameter int CH_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] pending
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] sh_q, sh_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             pend_q, pend_d;
    logic             wr;
    logic             on;
    logic             wrap;

    assign wr   = cfg_we && (cfg_ch == CH_W'(g));
    assign on   = (act_q != '0);
    assign wrap = on && (cnt_q == act_q - CNT_W'(1));

    always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      sh_d   = sh_q;
      tick_d = 1'b0;
      sq_d   = sq_q;
      pend_d = pend_q;
      if (sync) begin
        cnt_d  = '0;
        sq_d   = 1'b0;
        act_d  = wr ? cfg_div : sh_q;
        sh_d   = wr ? cfg_div : sh_q;
        pend_d = 1'b0;
      end else begin
        if (!on) begin
          cnt_d = '0;
        end else if (en) begin
          if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            sq_d   = ~sq_q;
            act_d  = sh_q;
            pend_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        // A write racing a wrap still lands in the shadow and stays pending.
        if (wr) begin
          sh_d = cfg_div;
          if (on) begin
            pend_d = 1'b1;
          end else begin
            act_d  = cfg_div;
            cnt_d  = '0;
            pend_d = 1'b0;
          end
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        act_q  <= CNT_W'(RESET_DIV);
        sh_q   <= CNT_W'(RESET_DIV);
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        sh_q   <= sh_d;
        tick_q <= tick_d;
        sq_q   <= sq_d;
        pend_q <= pend_d;
      end
    end

    assign tick[g]    = tick_q;
    assign sq[g]      = sq_q;
    assign pending[g] = pend_q;
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi: default rate, reprogramming,
// disable, enable gaps, sync realignment, bad writes and async reset.
module tb_clock_divider_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sync = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_ch = '0;
  logic [15:0] cfg_div = '0;
  logic [3:0]  tick, sq, pending;

  int checks = 0;
  int errors = 0;

  clock_divider_multi #(
    .NUM_CH(4), .CNT_W(16), .RESET_DIV(2), .CH_W(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .tick(tick), .sq(sq), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] ch, input logic [15:0] d);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_div = d;
  endtask

  logic [3:0] e;

  initial begin
    // reset state
    cyc(); cyc();
    chk("rst_tick", tick, 4'h0);
    chk("rst_sq", sq, 4'h0);
    chk("rst_pend", pending, 4'h0);
    rst = 1'b0; en = 1'b1;
    // edges 1..4, default ratio 2
    cyc(); chk("d2_e1_tick", tick, 4'h0);
    cyc(); chk("d2_e2_tick", tick, 4'hF); chk("d2_e2_sq", sq, 4'hF);
    cyc(); chk("d2_e3_tick", tick, 4'h0); chk("d2_e3_sq", sq, 4'hF);
    cyc(); chk("d2_e4_tick", tick, 4'hF); chk("d2_e4_sq", sq, 4'h0);
    // ch1 -> 5 mid-period
    wr(4'd1, 16'd5);
    cyc(); cfg_we = 1'b0;
    chk("ch1_pend", pending, 4'b0010);
    chk("ch1_e5_tick", tick, 4'h0);
    cyc();
    chk("ch1_e6_pend", pending, 4'h0);
    chk("ch1_e6_tick", tick, 4'hF);
    chk("ch1_e6_sq", sq, 4'hF);
    for (int k = 7; k <= 16; k++) begin
      cyc();
      e = (k % 2 == 0) ? 4'b1101 : 4'b0000;
      if (k == 11 || k == 16) e[1] = 1'b1;
      chk($sformatf("ch1_e%0d_tick", k), tick, e);
    end
    // ch2 disable then immediate reload at 3
    wr(4'd2, 16'd0);
    cyc(); cfg_we = 1'b0;
    chk("ch2_off_pend", pending, 4'b0100);
    cyc();
    chk("ch2_e18_tick", tick[2], 1'b1);
    chk("ch2_e18_sq", sq[2], 1'b1);
    chk("ch2_e18_pend", pending[2], 1'b0);
    cyc(); cyc();
    chk("ch2_e20_tick", tick, 4'b1001);
    chk("ch2_e20_sq", sq[2], 1'b1);
    wr(4'd2, 16'd3);
    cyc(); cfg_we = 1'b0;
    chk("ch2_load_pend", pending[2], 1'b0);
    cyc(); chk("ch2_e22_tick", tick[2], 1'b0);
    cyc(); chk("ch2_e23_tick", tick[2], 1'b0);
    cyc(); chk("ch2_e24_tick", tick[2], 1'b1);
    chk("ch2_e24_sq", sq[2], 1'b0);
    // ch0 -> 4, then en gap at cnt=2
    wr(4'd0, 16'd4);
    cyc(); cfg_we = 1'b0;
    cyc();
    chk("ch0_e26_tick", tick[0], 1'b1);
    chk("ch0_e26_sq", sq[0], 1'b1);
    cyc(); cyc();
    en = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk($sformatf("gap%0d_tick", k), tick, 4'h0);
      chk($sformatf("gap%0d_sq0", k), sq[0], 1'b1);
    end
    en = 1'b1;
    cyc(); chk("res_e36_tick0", tick[0], 1'b0);
    cyc(); chk("res_e37_tick0", tick[0], 1'b1);
    chk("res_e37_sq0", sq[0], 1'b0);
    // sync with divs 3,4,5,7
    wr(4'd0, 16'd3); cyc();
    wr(4'd1, 16'd4); cyc();
    wr(4'd2, 16'd5); cyc();
    wr(4'd3, 16'd7); sync = 1'b1;
    cyc(); cfg_we = 1'b0; sync = 1'b0;
    chk("sync_tick", tick, 4'h0);
    chk("sync_sq", sq, 4'h0);
    chk("sync_pend", pending, 4'h0);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      e = {k % 7 == 0, k % 5 == 0, k % 4 == 0, k % 3 == 0};
      chk($sformatf("sync_k%0d_tick", k), tick, e);
    end
    // out-of-range write ignored
    wr(4'd4, 16'd9);
    cyc(); cfg_we = 1'b0;
    chk("bad_wr_pend", pending, 4'h0);
    chk("bad_wr_tick", tick, 4'b0010);
    wr(4'd2, 16'd6);
    cyc(); cfg_we = 1'b0;
    chk("pre_rst_tick", tick, 4'b0001);
    chk("pre_rst_pend", pending, 4'b0100);
    chk("pre_rst_sq0", sq[0], 1'b1);
    // async reset mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("arst_tick", tick, 4'h0);
    chk("arst_sq", sq, 4'h0);
    chk("arst_pend", pending, 4'h0);
    cyc();
    rst = 1'b0;
    cyc(); chk("post_e1_tick", tick, 4'h0);
    cyc(); chk("post_e2_tick", tick, 4'hF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
